// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver: pin conditioning, 11-bit frame capture and
// scancode assembly into the toggle-qualified ps2_key event bus.
module ps2_key_decoder #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        byte_stb,
  output logic [7:0]  byte_dat,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {F_IDLE, F_RECV} frame_t;
  typedef enum logic {S_BASE, S_SKIP} scan_t;

  // Index 0 carries ps2_clk, index 1 carries ps2_data.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_f_q;
  logic          fall, dbit;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= '1;
      sync2   <= '1;
      filt    <= '1;
      clk_f_q <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1   <= {ps2_data, ps2_clk};
      sync2   <= sync1;
      clk_f_q <= filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_f_q & ~filt[0];
  assign dbit = filt[1];

  // Frame FSM: bit_cnt 0..8 shifts data+parity, 9 is the stop bit.
  frame_t        fstate, fstate_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic [8:0]    shreg, shreg_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          stb_nxt, err_nxt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fstate    <= F_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      to_cnt    <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      byte_dat  <= '0;
    end else begin
      fstate    <= fstate_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      to_cnt    <= to_cnt_nxt;
      byte_stb  <= stb_nxt;
      frame_err <= err_nxt;
      if (stb_nxt) byte_dat <= shreg[7:0];
    end
  end

  always_comb begin
    fstate_nxt  = fstate;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    to_cnt_nxt  = (fall || fstate == F_IDLE) ? '0 : to_cnt + 1'b1;
    case (fstate)
      F_IDLE: begin
        if (fall && !dbit) begin
          fstate_nxt  = F_RECV;
          bit_cnt_nxt = '0;
        end
      end
      F_RECV: begin
        if (fall) begin
          if (bit_cnt == 4'd9) begin
            fstate_nxt = F_IDLE;
          end else begin
            shreg_nxt   = {dbit, shreg[8:1]};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          fstate_nxt = F_IDLE;
        end
      end
      default: fstate_nxt = F_IDLE;
    endcase
  end

  always_comb begin
    stb_nxt = 1'b0;
    err_nxt = 1'b0;
    case (fstate)
      F_IDLE: if (fall && dbit) err_nxt = 1'b1;
      F_RECV: begin
        if (fall && bit_cnt == 4'd9) begin
          if ((^shreg) && dbit) stb_nxt = 1'b1;
          else                  err_nxt = 1'b1;
        end else if (!fall && to_cnt == TW'(TIMEOUT - 1)) begin
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Scancode FSM: prefix flags and Pause skipping, advanced by byte_stb.
  scan_t       sstate, sstate_nxt;
  logic        ext, brk, ext_nxt, brk_nxt;
  logic [2:0]  skip_cnt, skip_cnt_nxt;
  logic [10:0] key_nxt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sstate   <= S_BASE;
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip_cnt <= '0;
      ps2_key  <= '0;
    end else begin
      sstate   <= sstate_nxt;
      ext      <= ext_nxt;
      brk      <= brk_nxt;
      skip_cnt <= skip_cnt_nxt;
      ps2_key  <= key_nxt;
    end
  end

  always_comb begin
    sstate_nxt   = sstate;
    skip_cnt_nxt = skip_cnt;
    if (frame_err) begin
      sstate_nxt = S_BASE;
    end else if (byte_stb) begin
      case (sstate)
        S_BASE: begin
          if (byte_dat == 8'hE1) begin
            sstate_nxt   = S_SKIP;
            skip_cnt_nxt = 3'd7;
          end
        end
        S_SKIP: begin
          skip_cnt_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) sstate_nxt = S_BASE;
        end
        default: sstate_nxt = S_BASE;
      endcase
    end
  end

  always_comb begin
    ext_nxt = ext;
    brk_nxt = brk;
    key_nxt = ps2_key;
    if (frame_err) begin
      ext_nxt = 1'b0;
      brk_nxt = 1'b0;
    end else if (byte_stb && sstate == S_BASE) begin
      case (byte_dat)
        8'hE0: ext_nxt = 1'b1;
        8'hF0: brk_nxt = 1'b1;
        8'hE1: ;
        default: begin
          key_nxt = {~ps2_key[10], ~brk, ext, byte_dat};
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed events.
module tb_ps2_key_decoder;

  localparam int unsigned TB_TIMEOUT = 2000;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        byte_stb;
  logic [7:0]  byte_dat;
  logic        frame_err;

  int checks  = 0;
  int errors  = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int s0, e0;

  ps2_key_decoder #(.FILT_LEN(8), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .byte_stb  (byte_stb),
    .byte_dat  (byte_dat),
    .frame_err (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (byte_stb)  stb_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic par_ok,
                                           input logic stop);
    logic p;
    p = ~^b;
    if (!par_ok) p = ~p;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(20);
      ps2_clk = 1'b0;
      wait_cyc(40);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame_of(b, 1'b1, 1'b1), 11);
  endtask

  task automatic mark;
    s0 = stb_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    wait_cyc(5);
    check("rst_key", 32'(ps2_key), 32'h000);
    check("rst_stb", 32'(byte_stb), 32'h0);
    check("rst_dat", 32'(byte_dat), 32'h00);
    check("rst_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    wait_cyc(20);

    // T1: plain make code
    mark();
    send_byte(8'h1D);
    check("t1_stb", 32'(stb_cnt - s0), 32'd1);
    check("t1_dat", 32'(byte_dat), 32'h1D);
    check("t1_key", 32'(ps2_key), 32'h61D);

    // T2: break
    send_byte(8'hF0);
    check("t2_f0_key", 32'(ps2_key), 32'h61D);
    send_byte(8'h1D);
    check("t2_key", 32'(ps2_key), 32'h01D);

    // T3: extended make/break and ext cleared afterwards
    send_byte(8'hE0);
    send_byte(8'h75);
    check("t3_ext_make", 32'(ps2_key), 32'h775);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("t3_ext_brk", 32'(ps2_key), 32'h175);
    send_byte(8'h16);
    check("t3_after", 32'(ps2_key), 32'h616);

    // T4: parity error, stop error, prefix cleared by error
    mark();
    send_bits(frame_of(8'h1C, 1'b0, 1'b1), 11);
    check("t4_par_err", 32'(err_cnt - e0), 32'd1);
    check("t4_par_stb", 32'(stb_cnt - s0), 32'd0);
    check("t4_par_key", 32'(ps2_key), 32'h616);
    mark();
    send_bits(frame_of(8'h1C, 1'b1, 1'b0), 11);
    check("t4_stop_err", 32'(err_cnt - e0), 32'd1);
    check("t4_stop_stb", 32'(stb_cnt - s0), 32'd0);
    send_byte(8'hE0);
    send_bits(frame_of(8'h1C, 1'b0, 1'b1), 11);
    send_byte(8'h6B);
    check("t4_prefix_clr", 32'(ps2_key), 32'h26B);

    // T5: Pause sequence emits nothing
    mark();
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    check("t5_stb", 32'(stb_cnt - s0), 32'd8);
    check("t5_dat", 32'(byte_dat), 32'h77);
    check("t5_key", 32'(ps2_key), 32'h26B);
    send_byte(8'h29);
    check("t5_next", 32'(ps2_key), 32'h629);

    // T6: glitch, timeout, reset mid-frame
    mark();
    ps2_clk = 1'b0;
    wait_cyc(4);
    ps2_clk = 1'b1;
    wait_cyc(40);
    check("t6_glitch_err", 32'(err_cnt - e0), 32'd0);
    check("t6_glitch_stb", 32'(stb_cnt - s0), 32'd0);

    mark();
    send_bits(frame_of(8'h29, 1'b1, 1'b1), 5);
    wait_cyc(TB_TIMEOUT + 100);
    check("t6_to_err", 32'(err_cnt - e0), 32'd1);
    check("t6_to_stb", 32'(stb_cnt - s0), 32'd0);
    check("t6_to_key", 32'(ps2_key), 32'h629);
    send_byte(8'h16);
    check("t6_after_to_key", 32'(ps2_key), 32'h216);
    check("t6_after_to_dat", 32'(byte_dat), 32'h16);

    send_bits(frame_of(8'h33, 1'b1, 1'b1), 4);
    reset_n = 1'b0;
    wait_cyc(3);
    check("t6_rst_key", 32'(ps2_key), 32'h000);
    check("t6_rst_dat", 32'(byte_dat), 32'h00);
    check("t6_rst_stb", 32'(byte_stb), 32'h0);
    check("t6_rst_err", 32'(frame_err), 32'h0);
    ps2_data = 1'b1;
    reset_n  = 1'b1;
    wait_cyc(20);
    mark();
    send_byte(8'h1D);
    check("t6_post_rst_key", 32'(ps2_key), 32'h61D);
    check("t6_post_rst_err", 32'(err_cnt - e0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
